// File: rtl/cva6_cfg_rom_responder.sv
// ============================================================================
// Module   : cva6_cfg_rom_responder
// Brief    : Memory-mapped read-side view of the elaborated CVA6 configuration.
//            OBI-style req/gnt + rvalid/rready port, 2-deep response FIFO,
//            32-bit access counter, illegal-access error flagging.
//            Optional macro CVA6_CFG_ROM_SCRATCH_EN maps word 7 to a 32-bit
//            R/W scratch register; without it word 7 is unmapped.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cva6_cfg_rom_responder #(
    parameter logic [31:0] XLEN          = 32'd32,
    parameter logic [31:0] ISA_BITMAP    = 32'h0000_0007,
    parameter logic [31:0] ICACHE_BYTES  = 32'd16384,
    parameter logic [31:0] DCACHE_BYTES  = 32'd32768,
    parameter logic [31:0] NR_SB_ENTRIES = 32'd4,
    parameter logic [31:0] NR_COMMIT     = 32'd1,
    parameter logic [31:0] NR_PMP        = 32'd8,
    parameter logic [31:0] WBUF_DEPTH    = 32'd8,
    parameter logic [31:0] ID_VALUE      = 32'hC7A6_0001
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [5:0]  addr_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam logic [31:0] C_WORD5 = {WBUF_DEPTH[7:0], NR_PMP[7:0],
                                       NR_COMMIT[7:0], NR_SB_ENTRIES[7:0]};
    localparam logic [1:0]  C_DEPTH = 2'd2;

    // Response FIFO state
    logic [1:0]  count_q, count_d;
    logic        wptr_q, wptr_d;
    logic        rptr_q, rptr_d;
    logic [31:0] mem_data_q [2];
    logic [31:0] mem_data_d [2];
    logic        mem_err_q  [2];
    logic        mem_err_d  [2];

    // Architectural state
    logic [31:0] acc_cnt_q, acc_cnt_d;
    logic [31:0] scratch_q, scratch_d;

    // Handshake and decode
    logic        push;
    logic        pop;
    logic [3:0]  word_idx;
    logic        misaligned;
    logic        dec_err;
    logic [31:0] dec_data;
    logic        scratch_wr;

    // No bypass: a full FIFO refuses requests even if it is draining this cycle.
    assign gnt_o      = req_i & (count_q < C_DEPTH);
    assign push       = req_i & gnt_o;
    assign rvalid_o   = (count_q != 2'd0);
    assign pop        = rvalid_o & rready_i;
    assign word_idx   = addr_i[5:2];
    assign misaligned = (addr_i[1:0] != 2'b00);

    // Head of FIFO drives the response; forced to zero when nothing is pending.
    assign rdata_o = rvalid_o ? mem_data_q[rptr_q] : 32'd0;
    assign err_o   = rvalid_o ? mem_err_q[rptr_q]  : 1'b0;

    // Address decode: read data and error classification for the current request
    always_comb begin
        dec_data   = 32'd0;
        dec_err    = 1'b0;
        scratch_wr = 1'b0;
        case (word_idx)
            4'd0: begin dec_data = ID_VALUE;     dec_err = we_i; end
            4'd1: begin dec_data = XLEN;         dec_err = we_i; end
            4'd2: begin dec_data = ISA_BITMAP;   dec_err = we_i; end
            4'd3: begin dec_data = ICACHE_BYTES; dec_err = we_i; end
            4'd4: begin dec_data = DCACHE_BYTES; dec_err = we_i; end
            4'd5: begin dec_data = C_WORD5;      dec_err = we_i; end
            // Counter value before this access is counted.
            4'd6: begin dec_data = acc_cnt_q;    dec_err = we_i; end
`ifdef CVA6_CFG_ROM_SCRATCH_EN
            4'd7: begin
                dec_data   = scratch_q;
                scratch_wr = we_i;
            end
`endif
            default: dec_err = 1'b1;
        endcase
        if (misaligned) begin
            dec_err    = 1'b1;
            scratch_wr = 1'b0;
        end
        // Writes (successful or not) and errors return zero data.
        if (we_i || dec_err) begin
            dec_data = 32'd0;
        end
    end

`ifndef CVA6_CFG_ROM_SCRATCH_EN
    // Write data has no destination when the scratch register is absent.
    logic unused_wdata;
    assign unused_wdata = ^wdata_i;
`endif

    // Next-state: FIFO push/pop, access counter, scratch register
    always_comb begin
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        mem_data_d = mem_data_q;
        mem_err_d  = mem_err_q;
        acc_cnt_d  = acc_cnt_q;
        scratch_d  = scratch_q;

        if (push) begin
            mem_data_d[wptr_q] = dec_data;
            mem_err_d[wptr_q]  = dec_err;
            wptr_d             = ~wptr_q;
            acc_cnt_d          = acc_cnt_q + 32'd1;
`ifdef CVA6_CFG_ROM_SCRATCH_EN
            if (scratch_wr) begin
                scratch_d = wdata_i;
            end
`endif
        end
        if (pop) begin
            rptr_d = ~rptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

`ifndef CVA6_CFG_ROM_SCRATCH_EN
    logic unused_scratch_wr;
    assign unused_scratch_wr = scratch_wr;
`endif

    // State registers; reset wins over any same-cycle accept or pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q       <= 2'd0;
            wptr_q        <= 1'b0;
            rptr_q        <= 1'b0;
            mem_data_q[0] <= 32'd0;
            mem_data_q[1] <= 32'd0;
            mem_err_q[0]  <= 1'b0;
            mem_err_q[1]  <= 1'b0;
            acc_cnt_q     <= 32'd0;
            scratch_q     <= 32'd0;
        end else begin
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mem_data_q <= mem_data_d;
            mem_err_q  <= mem_err_d;
            acc_cnt_q  <= acc_cnt_d;
            scratch_q  <= scratch_d;
        end
    end

endmodule

`default_nettype wire
